wb_rr_arbiter: RTL and testbench
================================

Name: wb_rr_arbiter

Overview:
- Two-master to one-slave Wishbone classic arbiter. It sits between the requesters (serial bridge as m0, second master such as DMA/CPU as m1) and the address-decode mux that fans out to the slaves.
- Grants the shared bus round-robin and holds the grant for the whole cyc_i period. Routes ack/err/read data back to the owner only.

Parameters:
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width; SEL width = DATA_WIDTH/8
- TIMEOUT_CYCLES, 256, watchdog limit; used only with WB_ARB_TIMEOUT_EN

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m0_adr_i / m1_adr_i  in  ADDR_WIDTH  master address
- m0_dat_i / m1_dat_i  in  DATA_WIDTH  master write data
- m0_dat_o / m1_dat_o  out  DATA_WIDTH  read data
- m0_we_i / m1_we_i  in  1  write enable
- m0_sel_i / m1_sel_i  in  DATA_WIDTH/8  byte selects
- m0_stb_i / m1_stb_i  in  1  strobe
- m0_cyc_i / m1_cyc_i  in  1  bus cycle request
- m0_ack_o / m1_ack_o  out  1  acknowledge
- m0_err_o / m1_err_o  out  1  error
- s_adr_o  out  ADDR_WIDTH  to decode mux
- s_dat_o  out  DATA_WIDTH  write data to slave
- s_dat_i  in  DATA_WIDTH  read data from slave
- s_we_o  out  1  write enable
- s_sel_o  out  DATA_WIDTH/8  byte selects
- s_stb_o  out  1  strobe
- s_cyc_o  out  1  cycle
- s_ack_i  in  1  slave acknowledge
- s_err_i  in  1  slave error
- gnt_o  out  2  registered one-hot owner; 00 = idle

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - state IDLE, gnt_o=00, last_owner=1 (m0 wins the first tie), timeout counter 0.
  - All *_ack_o, *_err_o, s_cyc_o and s_stb_o are 0.
- States: IDLE, OWN0, OWN1.
- IDLE:
  - Only m0_cyc_i high -> OWN0 next edge.
  - Only m1_cyc_i high -> OWN1 next edge.
  - Both high -> grant the master that is not last_owner.
  - Neither high -> stay in IDLE.
  - Arbitration latency is exactly 1 cycle from cyc_i rise to s_cyc_o rise.
- OWNn:
  - s_adr/dat/we/sel/stb/cyc are combinationally muxed from master n.
  - mn_ack_o = s_ack_i and mn_err_o = s_err_i. The other master's ack/err are held 0.
  - last_owner <= n on entry.
- Release: the cycle the owner's cyc_i is low, s_cyc_o and s_stb_o are 0 (combinational gating). The state goes to IDLE on the next edge.
- There is no direct OWN0<->OWN1 transition; a minimum 1-cycle IDLE turnaround always occurs between owners.
- A burst (owner holds cyc_i across several stb_i/ack pairs) keeps the grant. The other master waits regardless of how long it has been requesting.
- In IDLE, s_cyc_o=s_stb_o=s_we_o=0 and s_sel_o=0. s_adr_o and s_dat_o are driven 0.
- m0_dat_o and m1_dat_o both carry s_dat_i unconditionally. Masters qualify read data with their own ack.
- The slave asserting ack and err together is forwarded as-is.
- rst asserted mid-transfer: next edge -> IDLE, gnt_o=00, all outputs at reset values. An in-flight ack is not forwarded after the reset edge.
- A master dropping cyc_i while its stb_i is pending aborts the transfer; a late s_ack_i in IDLE is ignored.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - The counter increments each cycle that s_stb_o=1 and s_ack_i=0 and s_err_i=0. It clears on ack, err, IDLE, or rst.
  - When the counter reaches TIMEOUT_CYCLES-1 with no response, the owner's err_o is asserted for exactly one cycle (the next cycle). The counter then clears.
  - The grant is kept until the owner drops cyc_i.
- Not defined: no counter logic; a hung slave holds the bus indefinitely.

Test Plan:
- m0 single write adr=0x0000_0104 dat=0xDEADBEEF sel=F, slave acks 2 cycles after stb -> s_cyc_o rises 1 cycle after m0_cyc_i, gnt_o=01, m0_ack_o 1 cycle wide, m1_ack_o stays 0, IDLE 1 cycle after cyc drops.
- After reset, m0/m1 raise cyc in the same cycle and repeat 4 transactions each -> grants alternate 01,10,01,10…, starting with m0, with one IDLE cycle between each.
- m1 holds cyc for a 4-beat burst while m0 requests from beat 1 -> gnt_o stays 10 for all 4 acks; m0 is granted the cycle after m1 releases plus the IDLE turnaround.
- m0 read, slave returns s_dat_i=0x1234_5678 with err_i=1 -> m0_err_o=1 for 1 cycle, m1_err_o=0, m0_dat_o=0x1234_5678.
- rst pulsed while m1 owns and stb is pending -> next cycle gnt_o=00, s_cyc_o=0, no ack forwarded; after rst release with m0 and m1 both requesting, m0 wins.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks m0 -> m0_err_o pulses once after 16 cycles of s_stb_o; m0 drops cyc; m1's pending request is granted after the IDLE cycle.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Two-master to one-slave Wishbone classic arbiter. Round-robin grant held for the owner's whole cyc_i period.
// Optional slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_cyc_i,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_cyc_i,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic                    s_stb_o,
    output logic                    s_cyc_o,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    output logic [1:0]              gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic [1:0] gnt_q, gnt_d;
    logic       tmo_err;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("wb_rr_arbiter: TIMEOUT_CYCLES must be at least 2");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("wb_rr_arbiter: DATA_WIDTH must be a multiple of 8");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            gnt_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            gnt_q        <= gnt_d;
        end
    end

    // Owners always return to IDLE before a new grant, giving a one-cycle turnaround.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_owner_q)) begin
                    state_d      = OWN0;
                    last_owner_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d      = OWN1;
                    last_owner_d = 1'b1;
                end
            end
            OWN0:    if (!m0_cyc_i) state_d = IDLE;
            OWN1:    if (!m1_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        gnt_d = {state_d == OWN1, state_d == OWN0};
    end

    assign gnt_o    = gnt_q;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            OWN0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_stb_o  = m0_stb_i & m0_cyc_i;
                s_cyc_o  = m0_cyc_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | tmo_err;
            end
            OWN1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_stb_o  = m1_stb_i & m1_cyc_i;
                s_cyc_o  = m1_cyc_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | tmo_err;
            end
            default: ;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             stall;

    // Counts unanswered strobe cycles; any response or loss of ownership restarts it.
    always_comb begin
        stall = s_stb_o & ~s_ack_i & ~s_err_i;
        cnt_d = '0;
        tmo_d = 1'b0;
        if (stall && state_q != IDLE) begin
            if (cnt_q == CNT_LAST) tmo_d = 1'b1;
            else                   cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign tmo_err = tmo_q;
`else
    assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a scoreboard queue holds the expected owner responses.
// Define WB_ARB_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES=16.
module tb_wb_rr_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic          m0_we_i, m1_we_i, s_we_o;
    logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic          m0_stb_i, m1_stb_i, m0_cyc_i, m1_cyc_i;
    logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic          s_stb_o, s_cyc_o, s_ack_i, s_err_i;
    logic [1:0]    gnt_o;

    logic man_ack, man_err, slv_en;
    logic auto_ack = 1'b0;

    typedef struct packed {
        logic [1:0]    gnt;
        logic          a0, a1, e0, e1;
        logic [DW-1:0] d0, d1;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_obs, mon_exp;
    int   total = 0;
    int   bad   = 0;
    int   rem0, rem1, n;
    bit   ok, own0;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i), .gnt_o(gnt_o)
    );

    // Simple slave: when enabled it acks one cycle after seeing a strobe.
    assign s_ack_i = man_ack | auto_ack;
    assign s_err_i = man_err;
    always @(posedge clk) auto_ack <= slv_en && s_stb_o && !auto_ack && !rst;

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t mk(input logic [1:0] g, input logic a0, input logic a1,
                                input logic e0, input logic e1, input logic [DW-1:0] d);
        return {g, a0, a1, e0, e1, d, d};
    endfunction

    // Every ack/err seen by a master must match the next scoreboard entry.
    always @(negedge clk) begin
        if (m0_ack_o || m1_ack_o || m0_err_o || m1_err_o) begin
            mon_obs = {gnt_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o};
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", mon_obs, '0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rsp", mon_obs, mon_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int max, output bit got, output int cycles);
        got    = 1'b0;
        cycles = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (m0_ack_o || m1_ack_o || m0_err_o || m1_err_o) begin
                got    = 1'b1;
                cycles = i;
                break;
            end
        end
        if (!got) chk("rsp_timeout", 70'd1, 70'd0);
    endtask

    task automatic m0_set(input logic cyc, input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat);
        m0_cyc_i = cyc; m0_stb_i = cyc; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
        m0_sel_i = cyc ? 4'hF : 4'h0;
    endtask

    task automatic m1_set(input logic cyc, input logic we, input logic [AW-1:0] adr,
                          input logic [DW-1:0] dat);
        m1_cyc_i = cyc; m1_stb_i = cyc; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
        m1_sel_i = cyc ? 4'hF : 4'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog observed=running expected=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rst = 1'b1; man_ack = 1'b0; man_err = 1'b0; slv_en = 1'b0; s_dat_i = '0;
        m0_set(1'b0, 1'b0, '0, '0);
        m1_set(1'b0, 1'b0, '0, '0);
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", 70'(gnt_o), 70'd0);
        chk("rst_bus", 70'({s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 70'd0);

        // m0 single write, slave acks two cycles after the strobe
        tick();
        m0_set(1'b1, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_latency_cyc", 70'(s_cyc_o), 70'd0);
        tick();
        chk("wr_gnt", 70'(gnt_o), 70'd1);
        chk("wr_bus", 70'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}),
            70'({1'b1, 1'b1, 1'b1, 4'hF, 32'h0000_0104, 32'hDEAD_BEEF}));
        tick();
        tick();
        man_ack = 1'b1;
        exp_q.push_back(mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, '0));
        tick();
        man_ack = 1'b0;
        m0_set(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("wr_release", 70'({s_cyc_o, s_stb_o, gnt_o}), 70'({1'b0, 1'b0, 2'b01}));
        tick();
        @(negedge clk);
        chk("wr_idle", 70'(gnt_o), 70'd0);

        // Round robin: both request together after reset, four transfers each
        rst = 1'b1;
        tick();
        rst = 1'b0;
        slv_en = 1'b1;
        s_dat_i = 32'hA5A5_0F0F;
        m0_set(1'b1, 1'b0, 32'h10, '0);
        m1_set(1'b1, 1'b0, 32'h20, '0);
        for (int k = 0; k < 8; k++)
            exp_q.push_back(mk((k % 2 == 0) ? 2'b01 : 2'b10, k % 2 == 0, k % 2 == 1,
                               1'b0, 1'b0, 32'hA5A5_0F0F));
        rem0 = 4;
        rem1 = 4;
        for (int k = 0; k < 8; k++) begin
            wait_rsp(10, ok, n);
            if (!ok) break;
            own0 = m0_ack_o;
            if (own0) rem0--; else rem1--;
            tick();
            if (own0) m0_set(1'b0, 1'b0, '0, '0); else m1_set(1'b0, 1'b0, '0, '0);
            tick();
            if (own0 && rem0 > 0) m0_set(1'b1, 1'b0, 32'h10, '0);
            if (!own0 && rem1 > 0) m1_set(1'b1, 1'b0, 32'h20, '0);
            @(negedge clk);
            chk("rr_turnaround", 70'(gnt_o), 70'd0);
        end

        // m1 four-beat burst keeps the grant while m0 waits
        tick();
        m1_set(1'b1, 1'b1, 32'h30, 32'h1111_2222);
        tick();
        m0_set(1'b1, 1'b1, 32'h40, 32'h3333_4444);
        for (int k = 0; k < 4; k++)
            exp_q.push_back(mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_0F0F));
        for (int k = 0; k < 4; k++) begin
            wait_rsp(10, ok, n);
            if (!ok) break;
        end
        tick();
        m1_set(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("burst_release", 70'({s_cyc_o, gnt_o}), 70'({1'b0, 2'b10}));
        tick();
        @(negedge clk);
        chk("burst_idle", 70'(gnt_o), 70'd0);
        exp_q.push_back(mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA5A5_0F0F));
        tick();
        @(negedge clk);
        chk("burst_m0_gnt", 70'({gnt_o, s_adr_o}), 70'({2'b01, 32'h40}));
        wait_rsp(10, ok, n);
        tick();
        m0_set(1'b0, 1'b0, '0, '0);
        tick(); tick();

        // m0 read answered with err, then with ack+err together
        slv_en = 1'b0;
        s_dat_i = 32'h1234_5678;
        m0_set(1'b1, 1'b0, 32'h50, '0);
        tick();
        man_err = 1'b1;
        exp_q.push_back(mk(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678));
        tick();
        man_err = 1'b0;
        tick();
        man_ack = 1'b1;
        man_err = 1'b1;
        exp_q.push_back(mk(2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5678));
        tick();
        man_ack = 1'b0;
        man_err = 1'b0;
        m0_set(1'b0, 1'b0, '0, '0);
        tick(); tick();

        // Reset while m1 owns with a strobe pending; a late ack must be dropped
        m1_set(1'b1, 1'b1, 32'h60, 32'h5555_6666);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_pre", 70'(gnt_o), 70'd2);
        tick();
        rst = 1'b0;
        man_ack = 1'b1;
        m0_set(1'b1, 1'b0, 32'h70, '0);
        @(negedge clk);
        chk("rst_mid_post", 70'({gnt_o, s_cyc_o, s_stb_o}), 70'd0);
        tick();
        man_ack = 1'b0;
        @(negedge clk);
        chk("rst_m0_wins", 70'(gnt_o), 70'd1);
        slv_en = 1'b1;
        exp_q.push_back(mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678));
        wait_rsp(10, ok, n);
        tick();
        m0_set(1'b0, 1'b0, '0, '0);
        exp_q.push_back(mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678));
        wait_rsp(10, ok, n);
        tick();
        m1_set(1'b0, 1'b0, '0, '0);
        tick(); tick();

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: slave never answers m0
        slv_en = 1'b0;
        m0_set(1'b1, 1'b0, 32'h80, '0);
        tick();
        m1_set(1'b1, 1'b0, 32'h90, '0);
        exp_q.push_back(mk(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678));
        wait_rsp(40, ok, n);
        chk("tmo_cycles", 70'(n), 70'd16);
        tick();
        m0_set(1'b0, 1'b0, '0, '0);
        tick();
        @(negedge clk);
        chk("tmo_idle", 70'(gnt_o), 70'd0);
        slv_en = 1'b1;
        exp_q.push_back(mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678));
        wait_rsp(10, ok, n);
        tick();
        m1_set(1'b0, 1'b0, '0, '0);
        tick(); tick();
`endif

        chk("sb_empty", 70'(exp_q.size()), 70'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
